// File: rtl/wb_rr_arb_4m_1s.sv
// Four-master to one-slave Wishbone round-robin arbiter with registered one-hot grant.
// Define WB_ARB_WDOG_EN to build in the stalled-strobe watchdog (ABORT state, counter, timeout pulse).
module wb_rr_arb_4m_1s #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        CLK,
    input  logic        RST_ASYNC_N,
    input  logic        EN,
    input  logic [31:0] WB_SL0_ADR_IN,
    input  logic        WB_SL0_CYC_IN,
    input  logic        WB_SL0_STB_IN,
    input  logic        WB_SL0_WE_IN,
    input  logic [3:0]  WB_SL0_SEL_IN,
    input  logic [2:0]  WB_SL0_CTI_IN,
    input  logic [1:0]  WB_SL0_BTE_IN,
    input  logic [31:0] WB_SL0_WR_DAT_IN,
    output logic        WB_SL0_STALL_OUT,
    output logic        WB_SL0_ACK_OUT,
    output logic        WB_SL0_ERR_OUT,
    output logic [31:0] WB_SL0_RD_DAT_OUT,
    input  logic [31:0] WB_SL1_ADR_IN,
    input  logic        WB_SL1_CYC_IN,
    input  logic        WB_SL1_STB_IN,
    input  logic        WB_SL1_WE_IN,
    input  logic [3:0]  WB_SL1_SEL_IN,
    input  logic [2:0]  WB_SL1_CTI_IN,
    input  logic [1:0]  WB_SL1_BTE_IN,
    input  logic [31:0] WB_SL1_WR_DAT_IN,
    output logic        WB_SL1_STALL_OUT,
    output logic        WB_SL1_ACK_OUT,
    output logic        WB_SL1_ERR_OUT,
    output logic [31:0] WB_SL1_RD_DAT_OUT,
    input  logic [31:0] WB_SL2_ADR_IN,
    input  logic        WB_SL2_CYC_IN,
    input  logic        WB_SL2_STB_IN,
    input  logic        WB_SL2_WE_IN,
    input  logic [3:0]  WB_SL2_SEL_IN,
    input  logic [2:0]  WB_SL2_CTI_IN,
    input  logic [1:0]  WB_SL2_BTE_IN,
    input  logic [31:0] WB_SL2_WR_DAT_IN,
    output logic        WB_SL2_STALL_OUT,
    output logic        WB_SL2_ACK_OUT,
    output logic        WB_SL2_ERR_OUT,
    output logic [31:0] WB_SL2_RD_DAT_OUT,
    input  logic [31:0] WB_SL3_ADR_IN,
    input  logic        WB_SL3_CYC_IN,
    input  logic        WB_SL3_STB_IN,
    input  logic        WB_SL3_WE_IN,
    input  logic [3:0]  WB_SL3_SEL_IN,
    input  logic [2:0]  WB_SL3_CTI_IN,
    input  logic [1:0]  WB_SL3_BTE_IN,
    input  logic [31:0] WB_SL3_WR_DAT_IN,
    output logic        WB_SL3_STALL_OUT,
    output logic        WB_SL3_ACK_OUT,
    output logic        WB_SL3_ERR_OUT,
    output logic [31:0] WB_SL3_RD_DAT_OUT,
    output logic [31:0] WB_M0_ADR_OUT,
    output logic        WB_M0_CYC_OUT,
    output logic        WB_M0_STB_OUT,
    output logic        WB_M0_WE_OUT,
    output logic [3:0]  WB_M0_SEL_OUT,
    output logic [2:0]  WB_M0_CTI_OUT,
    output logic [1:0]  WB_M0_BTE_OUT,
    output logic [31:0] WB_M0_WR_DAT_OUT,
    input  logic        WB_M0_STALL_IN,
    input  logic        WB_M0_ACK_IN,
    input  logic        WB_M0_ERR_IN,
    input  logic [31:0] WB_M0_RD_DAT_IN,
    output logic [3:0]  ARB_GNT_OUT,
    output logic        ARB_TIMEOUT_OUT
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN   = 2'd1;
`ifdef WB_ARB_WDOG_EN
    localparam logic [1:0] ST_ABORT = 2'd2;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
`endif

    logic [3:0]       cyc, stb, we;
    logic [3:0][31:0] adr, wdat;
    logic [3:0][3:0]  sel;
    logic [3:0][2:0]  cti;
    logic [3:0][1:0]  bte;
    logic [3:0]       s_stall, s_ack, s_err;
    logic [3:0][31:0] s_rdat;

    logic [1:0] state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] last_q, last_d;
    logic [1:0] win;
    logic       grant_new;

    logic        m_cyc, m_stb, m_we;
    logic [31:0] m_adr, m_wdat;
    logic [3:0]  m_sel;
    logic [2:0]  m_cti;
    logic [1:0]  m_bte;

    assign cyc  = {WB_SL3_CYC_IN, WB_SL2_CYC_IN, WB_SL1_CYC_IN, WB_SL0_CYC_IN};
    assign stb  = {WB_SL3_STB_IN, WB_SL2_STB_IN, WB_SL1_STB_IN, WB_SL0_STB_IN};
    assign we   = {WB_SL3_WE_IN, WB_SL2_WE_IN, WB_SL1_WE_IN, WB_SL0_WE_IN};
    assign adr  = {WB_SL3_ADR_IN, WB_SL2_ADR_IN, WB_SL1_ADR_IN, WB_SL0_ADR_IN};
    assign wdat = {WB_SL3_WR_DAT_IN, WB_SL2_WR_DAT_IN, WB_SL1_WR_DAT_IN, WB_SL0_WR_DAT_IN};
    assign sel  = {WB_SL3_SEL_IN, WB_SL2_SEL_IN, WB_SL1_SEL_IN, WB_SL0_SEL_IN};
    assign cti  = {WB_SL3_CTI_IN, WB_SL2_CTI_IN, WB_SL1_CTI_IN, WB_SL0_CTI_IN};
    assign bte  = {WB_SL3_BTE_IN, WB_SL2_BTE_IN, WB_SL1_BTE_IN, WB_SL0_BTE_IN};

    // Later iterations override earlier ones, so index last+1 has top priority.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = last;
        for (int unsigned k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    assign win = rr_pick(cyc, last_q);

`ifdef WB_ARB_WDOG_EN
    logic [7:0] cnt_q, cnt_d;
    logic       tmo_q, fire;
    assign fire = (state_q == ST_OWN) && cyc[last_q] && m_stb &&
                  !WB_M0_ACK_IN && !WB_M0_ERR_IN && (cnt_q == TMO_LAST);
`endif

    // last_q doubles as the owner index whenever a grant is held.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        grant_new = 1'b0;
        case (state_q)
            ST_IDLE: if (|cyc) grant_new = 1'b1;
            ST_OWN: begin
                if (!cyc[last_q]) begin
                    if (|cyc) grant_new = 1'b1;
                    else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end
`ifdef WB_ARB_WDOG_EN
                else if (fire) state_d = ST_ABORT;
`endif
            end
`ifdef WB_ARB_WDOG_EN
            ST_ABORT: begin
                if (!cyc[last_q]) begin
                    if (|cyc) grant_new = 1'b1;
                    else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
        if (grant_new) begin
            state_d = ST_OWN;
            gnt_d   = 4'b0001 << win;
            last_d  = win;
        end
    end

    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= 2'd3;
        end else if (EN) begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        m_cyc  = 1'b0;
        m_stb  = 1'b0;
        m_we   = 1'b0;
        m_adr  = '0;
        m_wdat = '0;
        m_sel  = '0;
        m_cti  = '0;
        m_bte  = '0;
        if (state_q == ST_OWN) begin
            m_cyc  = cyc[last_q];
            m_stb  = stb[last_q];
            m_we   = we[last_q];
            m_adr  = adr[last_q];
            m_wdat = wdat[last_q];
            m_sel  = sel[last_q];
            m_cti  = cti[last_q];
            m_bte  = bte[last_q];
        end
    end

    always_comb begin
        s_stall = cyc;
        s_ack   = '0;
        s_err   = '0;
        s_rdat  = '0;
        if (state_q == ST_OWN) begin
            s_stall[last_q] = WB_M0_STALL_IN;
            s_ack[last_q]   = WB_M0_ACK_IN;
            s_err[last_q]   = WB_M0_ERR_IN;
            s_rdat[last_q]  = WB_M0_RD_DAT_IN;
        end
`ifdef WB_ARB_WDOG_EN
        else if (state_q == ST_ABORT) begin
            s_stall[last_q] = 1'b1;
            s_err[last_q]   = tmo_q;
        end
`endif
    end

`ifdef WB_ARB_WDOG_EN
    always_comb begin
        cnt_d = cnt_q;
        if (grant_new || WB_M0_ACK_IN || WB_M0_ERR_IN) cnt_d = '0;
        else if (m_stb && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
    end

    // The pulse is not gated by EN so that it never stretches past one cycle.
    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= EN && fire;
            if (EN) cnt_q <= cnt_d;
        end
    end

    assign ARB_TIMEOUT_OUT = tmo_q;
`else
    assign ARB_TIMEOUT_OUT = 1'b0;
`endif

    assign ARB_GNT_OUT       = gnt_q;
    assign WB_M0_CYC_OUT     = m_cyc;
    assign WB_M0_STB_OUT     = m_stb;
    assign WB_M0_WE_OUT      = m_we;
    assign WB_M0_ADR_OUT     = m_adr;
    assign WB_M0_WR_DAT_OUT  = m_wdat;
    assign WB_M0_SEL_OUT     = m_sel;
    assign WB_M0_CTI_OUT     = m_cti;
    assign WB_M0_BTE_OUT     = m_bte;

    assign WB_SL0_STALL_OUT  = s_stall[0];
    assign WB_SL0_ACK_OUT    = s_ack[0];
    assign WB_SL0_ERR_OUT    = s_err[0];
    assign WB_SL0_RD_DAT_OUT = s_rdat[0];
    assign WB_SL1_STALL_OUT  = s_stall[1];
    assign WB_SL1_ACK_OUT    = s_ack[1];
    assign WB_SL1_ERR_OUT    = s_err[1];
    assign WB_SL1_RD_DAT_OUT = s_rdat[1];
    assign WB_SL2_STALL_OUT  = s_stall[2];
    assign WB_SL2_ACK_OUT    = s_ack[2];
    assign WB_SL2_ERR_OUT    = s_err[2];
    assign WB_SL2_RD_DAT_OUT = s_rdat[2];
    assign WB_SL3_STALL_OUT  = s_stall[3];
    assign WB_SL3_ACK_OUT    = s_ack[3];
    assign WB_SL3_ERR_OUT    = s_err[3];
    assign WB_SL3_RD_DAT_OUT = s_rdat[3];

endmodule

// File: tb/tb_wb_rr_arb_4m_1s.sv
// Bench for wb_rr_arb_4m_1s: directed table, hand-written corner sequences and random traffic
// compared against a behavioural model of ownership, round-robin search and the watchdog.
module tb_wb_rr_arb_4m_1s;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n, en;
    logic [3:0]  sl_cyc, sl_stb, sl_we;
    logic [31:0] sl_adr  [4];
    logic [31:0] sl_wdat [4];
    logic [3:0]  sl_sel  [4];
    logic [2:0]  sl_cti  [4];
    logic [1:0]  sl_bte  [4];
    wire  [3:0]  sl_stall, sl_ack, sl_err;
    wire  [31:0] sl_rdat [4];
    wire  [31:0] m_adr, m_wdat;
    wire         m_cyc, m_stb, m_we;
    wire  [3:0]  m_sel;
    wire  [2:0]  m_cti;
    wire  [1:0]  m_bte;
    logic        m_stall_in, m_ack_in, m_err_in;
    logic [31:0] m_rdat_in;
    wire  [3:0]  gnt;
    wire         tmo;

    int n_chk = 0;
    int n_err = 0;

    // Model: owner index (-1 = none), last owner, abort flag, wait counter, timeout pulse.
    int m_own, m_last, m_cnt, n_own, n_last, n_cnt;
    bit m_abort, m_tmo, n_abort, n_tmo;

    typedef struct {
        logic [3:0]  cyc;
        logic        ack;
        logic [3:0]  exp_gnt;
        logic        exp_mcyc;
        logic [31:0] exp_adr;
        logic [3:0]  exp_stall;
        logic [3:0]  exp_ack;
    } vec_t;
    vec_t tbl [13];

    always #5 clk = ~clk;

    wb_rr_arb_4m_1s #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK(clk), .RST_ASYNC_N(rst_n), .EN(en),
        .WB_SL0_ADR_IN(sl_adr[0]), .WB_SL0_CYC_IN(sl_cyc[0]), .WB_SL0_STB_IN(sl_stb[0]),
        .WB_SL0_WE_IN(sl_we[0]), .WB_SL0_SEL_IN(sl_sel[0]), .WB_SL0_CTI_IN(sl_cti[0]),
        .WB_SL0_BTE_IN(sl_bte[0]), .WB_SL0_WR_DAT_IN(sl_wdat[0]),
        .WB_SL0_STALL_OUT(sl_stall[0]), .WB_SL0_ACK_OUT(sl_ack[0]),
        .WB_SL0_ERR_OUT(sl_err[0]), .WB_SL0_RD_DAT_OUT(sl_rdat[0]),
        .WB_SL1_ADR_IN(sl_adr[1]), .WB_SL1_CYC_IN(sl_cyc[1]), .WB_SL1_STB_IN(sl_stb[1]),
        .WB_SL1_WE_IN(sl_we[1]), .WB_SL1_SEL_IN(sl_sel[1]), .WB_SL1_CTI_IN(sl_cti[1]),
        .WB_SL1_BTE_IN(sl_bte[1]), .WB_SL1_WR_DAT_IN(sl_wdat[1]),
        .WB_SL1_STALL_OUT(sl_stall[1]), .WB_SL1_ACK_OUT(sl_ack[1]),
        .WB_SL1_ERR_OUT(sl_err[1]), .WB_SL1_RD_DAT_OUT(sl_rdat[1]),
        .WB_SL2_ADR_IN(sl_adr[2]), .WB_SL2_CYC_IN(sl_cyc[2]), .WB_SL2_STB_IN(sl_stb[2]),
        .WB_SL2_WE_IN(sl_we[2]), .WB_SL2_SEL_IN(sl_sel[2]), .WB_SL2_CTI_IN(sl_cti[2]),
        .WB_SL2_BTE_IN(sl_bte[2]), .WB_SL2_WR_DAT_IN(sl_wdat[2]),
        .WB_SL2_STALL_OUT(sl_stall[2]), .WB_SL2_ACK_OUT(sl_ack[2]),
        .WB_SL2_ERR_OUT(sl_err[2]), .WB_SL2_RD_DAT_OUT(sl_rdat[2]),
        .WB_SL3_ADR_IN(sl_adr[3]), .WB_SL3_CYC_IN(sl_cyc[3]), .WB_SL3_STB_IN(sl_stb[3]),
        .WB_SL3_WE_IN(sl_we[3]), .WB_SL3_SEL_IN(sl_sel[3]), .WB_SL3_CTI_IN(sl_cti[3]),
        .WB_SL3_BTE_IN(sl_bte[3]), .WB_SL3_WR_DAT_IN(sl_wdat[3]),
        .WB_SL3_STALL_OUT(sl_stall[3]), .WB_SL3_ACK_OUT(sl_ack[3]),
        .WB_SL3_ERR_OUT(sl_err[3]), .WB_SL3_RD_DAT_OUT(sl_rdat[3]),
        .WB_M0_ADR_OUT(m_adr), .WB_M0_CYC_OUT(m_cyc), .WB_M0_STB_OUT(m_stb),
        .WB_M0_WE_OUT(m_we), .WB_M0_SEL_OUT(m_sel), .WB_M0_CTI_OUT(m_cti),
        .WB_M0_BTE_OUT(m_bte), .WB_M0_WR_DAT_OUT(m_wdat),
        .WB_M0_STALL_IN(m_stall_in), .WB_M0_ACK_IN(m_ack_in),
        .WB_M0_ERR_IN(m_err_in), .WB_M0_RD_DAT_IN(m_rdat_in),
        .ARB_GNT_OUT(gnt), .ARB_TIMEOUT_OUT(tmo)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_own = -1; m_last = 3; m_abort = 1'b0; m_cnt = 0; m_tmo = 1'b0;
    endtask

    task automatic check_cycle();
        logic [75:0]  e_m, a_m;
        logic [139:0] e_r, a_r;
        logic [34:0]  e;
        logic [3:0]   e_gnt;
        bit           pass_on;
        pass_on = (m_own >= 0) && !m_abort;
        e_gnt   = (m_own >= 0) ? 4'(1 << m_own) : 4'b0000;
        e_m     = '0;
        if (pass_on)
            e_m = {sl_cyc[m_own], sl_stb[m_own], sl_we[m_own], sl_sel[m_own], sl_cti[m_own],
                   sl_bte[m_own], sl_adr[m_own], sl_wdat[m_own]};
        a_m = {m_cyc, m_stb, m_we, m_sel, m_cti, m_bte, m_adr, m_wdat};
        for (int i = 0; i < 4; i++) begin
            if (i == m_own && pass_on) e = {m_stall_in, m_ack_in, m_err_in, m_rdat_in};
            else if (i == m_own)       e = {1'b1, 1'b0, m_tmo, 32'h0};
            else                       e = {sl_cyc[i], 2'b00, 32'h0};
            e_r[i*35 +: 35] = e;
            a_r[i*35 +: 35] = {sl_stall[i], sl_ack[i], sl_err[i], sl_rdat[i]};
        end
        chk("model_gnt_tmo", {gnt, tmo}, {e_gnt, m_tmo});
        chk("model_m_bundle", a_m, e_m);
        chk("model_responses", a_r, e_r);
    endtask

    task automatic model_compute();
        bit fire, pass_on;
        pass_on = (m_own >= 0) && !m_abort;
        fire = 1'b0;
`ifdef WB_ARB_WDOG_EN
        fire = pass_on && sl_cyc[m_own] && sl_stb[m_own] && !m_ack_in && !m_err_in &&
               (m_cnt == int'(TMO) - 1);
`endif
        n_own = m_own; n_last = m_last; n_abort = m_abort; n_cnt = m_cnt;
        n_tmo = en && fire;
        if (en) begin
            if (m_ack_in || m_err_in) n_cnt = 0;
            else if (pass_on && sl_stb[m_own] && m_cnt < 255) n_cnt = m_cnt + 1;
            if (m_own < 0 || !sl_cyc[m_own]) begin
                n_own = -1; n_abort = 1'b0;
                for (int j = 1; j <= 4; j++)
                    if (n_own < 0 && sl_cyc[(m_last + j) % 4]) n_own = (m_last + j) % 4;
                if (n_own >= 0) begin
                    n_last = n_own;
                    n_cnt  = 0;
                end
            end else if (fire) n_abort = 1'b1;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic advance();
        model_compute();
        @(posedge clk);
        m_own = n_own; m_last = n_last; m_abort = n_abort; m_cnt = n_cnt; m_tmo = n_tmo;
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b1; sl_cyc = '0; sl_stb = '0;
        m_ack_in = 1'b0; m_err_in = 1'b0;
        model_reset();
        #2;
        chk("rst_gnt", gnt, 0);
        chk("rst_tmo", tmo, 0);
        chk("rst_mcyc_stb", {m_cyc, m_stb}, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 4; i++) begin
            if (sl_cyc[i]) begin
                if ($urandom_range(0, 5) == 0) sl_cyc[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) sl_cyc[i] = 1'b1;
            sl_stb[i]  = sl_cyc[i] & ($urandom_range(0, 3) != 0);
            sl_we[i]   = 1'($urandom);
            sl_adr[i]  = $urandom;
            sl_wdat[i] = $urandom;
            sl_sel[i]  = 4'($urandom);
            sl_cti[i]  = 3'($urandom);
            sl_bte[i]  = 2'($urandom);
        end
        m_ack_in   = ($urandom_range(0, 2) == 0);
        m_err_in   = ($urandom_range(0, 19) == 0);
        m_stall_in = 1'($urandom);
        m_rdat_in  = $urandom;
        en         = ($urandom_range(0, 9) != 0);
    endtask

    initial begin
        bit saw_tmo;
        for (int i = 0; i < 4; i++) begin
            sl_adr[i] = 32'hA000_0000 | 32'(i); sl_wdat[i] = 32'h5000_0000 | 32'(i);
            sl_sel[i] = 4'hF; sl_cti[i] = 3'd0; sl_bte[i] = 2'd0;
        end
        sl_we = '0; m_stall_in = 1'b0; m_rdat_in = 32'hDEAD_BEEF;

        //            cyc      ack   gnt      mcyc  adr            stall    ack_out
        tbl[0]  = '{4'b0100, 1'b0, 4'b0000, 1'b0, 32'h0,         4'b0100, 4'b0000};
        tbl[1]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 32'hA000_0002, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 32'hA000_0002, 4'b1011, 4'b0100};
        tbl[3]  = '{4'b1011, 1'b0, 4'b0100, 1'b0, 32'hA000_0002, 4'b1011, 4'b0000};
        tbl[4]  = '{4'b1011, 1'b0, 4'b1000, 1'b1, 32'hA000_0003, 4'b0011, 4'b0000};
        tbl[5]  = '{4'b0011, 1'b0, 4'b1000, 1'b0, 32'hA000_0003, 4'b0011, 4'b0000};
        tbl[6]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 32'hA000_0000, 4'b0010, 4'b0001};
        tbl[7]  = '{4'b0010, 1'b0, 4'b0001, 1'b0, 32'hA000_0000, 4'b0010, 4'b0000};
        tbl[8]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 32'hA000_0001, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b0000, 1'b0, 4'b0010, 1'b0, 32'hA000_0001, 4'b0000, 4'b0000};
        tbl[10] = '{4'b0001, 1'b0, 4'b0000, 1'b0, 32'h0,         4'b0001, 4'b0000};
        tbl[11] = '{4'b0000, 1'b0, 4'b0001, 1'b0, 32'hA000_0000, 4'b0000, 4'b0000};
        tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0000};

        do_reset();
        for (int r = 0; r < 13; r++) begin
            sl_cyc = tbl[r].cyc; sl_stb = tbl[r].cyc; m_ack_in = tbl[r].ack;
            sample();
            chk($sformatf("tbl%0d_gnt", r), gnt, tbl[r].exp_gnt);
            chk($sformatf("tbl%0d_mcyc", r), m_cyc, tbl[r].exp_mcyc);
            chk($sformatf("tbl%0d_adr", r), m_adr, tbl[r].exp_adr);
            chk($sformatf("tbl%0d_stall", r), sl_stall, tbl[r].exp_stall);
            chk($sformatf("tbl%0d_ack", r), sl_ack, tbl[r].exp_ack);
            advance();
        end

        // Asynchronous reset mid-burst, then master 0 wins the first arbitration.
        do_reset();
        sl_cyc = 4'b0010; sl_stb = 4'b0010;
        for (int k = 0; k < 3; k++) cycle();
        sl_cyc = 4'b1111; sl_stb = 4'b1111;
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_gnt", gnt, 0);
        chk("async_rst_mcyc_stb", {m_cyc, m_stb}, 0);
        #2 rst_n = 1'b1;
        advance();
        sample();
        chk("post_rst_gnt", gnt, 4'b0001);
        advance();

`ifdef WB_ARB_WDOG_EN
        do_reset();
        sl_cyc = 4'b1000; sl_stb = 4'b1000;
        for (int k = 0; k <= 8; k++) begin
            if (k == 7) begin
                sl_cyc = '0; sl_stb = '0;
            end
            sample();
            if (k == 4) chk("wdog_before", {sl_err[3], tmo, m_cyc}, 3'b001);
            if (k == 5) chk("wdog_fire", {sl_err[3], tmo, m_cyc}, 3'b110);
            if (k == 6) chk("wdog_abort", {sl_err[3], tmo, m_cyc, sl_stall[3]}, 4'b0001);
            if (k == 7) chk("wdog_hold_gnt", gnt, 4'b1000);
            if (k == 8) chk("wdog_release_gnt", gnt, 4'b0000);
            advance();
        end
`else
        do_reset();
        sl_cyc = 4'b1000; sl_stb = 4'b1000;
        saw_tmo = 1'b0;
        for (int k = 0; k < 60; k++) begin
            sample();
            if (tmo) saw_tmo = 1'b1;
            advance();
        end
        sample();
        chk("nowdog_gnt_held", gnt, 4'b1000);
        chk("nowdog_no_tmo", saw_tmo, 1'b0);
        advance();
`endif

        do_reset();
        for (int k = 0; k < 1500; k++) begin
            rand_inputs();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_rr_arb_4m_1s.md
WB_RR_ARB_4M_1S -- requirements
Module: wb_rr_arb_4m_1s

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 64, cycles without ACK/ERR on an outstanding strobe before the watchdog abort (legal range 2..255).
REQ-002 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port: RST_ASYNC_N  input  1  asynchronous, active-low reset.
REQ-004 Port: EN  input  1  clock enable for all state; when low, the grant, state, pointer and counter hold.
REQ-005 Ports: WB_SLn_ADR_IN/CYC_IN/STB_IN/WE_IN/SEL_IN/CTI_IN/BTE_IN/WR_DAT_IN  input  32/1/1/1/4/3/2/32  master-side request bundle, for n = 0..3.
REQ-006 Ports: WB_SLn_STALL_OUT/ACK_OUT/ERR_OUT/RD_DAT_OUT  output  1/1/1/32  master-side response bundle, for n = 0..3.
REQ-007 Ports: WB_M0_ADR_OUT/CYC_OUT/STB_OUT/WE_OUT/SEL_OUT/CTI_OUT/BTE_OUT/WR_DAT_OUT  output  32/1/1/1/4/3/2/32  slave-side request.
REQ-008 Ports: WB_M0_STALL_IN/ACK_IN/ERR_IN/RD_DAT_IN  input  1/1/1/32  slave-side response.
REQ-009 Port: ARB_GNT_OUT  output  4  registered one-hot grant; 4'b0000 when no master owns the bus.
REQ-010 Port: ARB_TIMEOUT_OUT  output  1  one-cycle pulse when the watchdog aborts a cycle.

Function
REQ-011 The FSM shall have exactly three states: IDLE (no grant), OWN (one master granted) and ABORT (watchdog fired, waiting for the owner to release CYC).
REQ-012 Each master's CYC_IN shall be its request line; the grant shall be held for as long as the owner keeps CYC_IN high (no preemption).
REQ-013 Selection shall be round-robin: the search starts at index (last owner + 1) mod 4; out of reset the last owner shall be 3, so master 0 wins first.
REQ-014 IDLE -> OWN: when any CYC_IN is high at an edge, the winner's grant bit shall be visible from the next cycle (one-cycle grant latency).
REQ-015 OWN with owner CYC_IN low: the next winner shall be granted at that edge with no idle cycle; if there is no other request, the FSM shall go to IDLE.
REQ-016 When granted, the owner's request bundle shall pass combinationally to WB_M0_*, and the slave's STALL/ACK/ERR/RD_DAT shall pass to the owner.
REQ-017 With no grant, WB_M0_* outputs shall be all zero.
REQ-018 A non-owner shall see STALL_OUT = its own CYC_IN, and ACK/ERR/RD_DAT = 0.
REQ-019 The last-owner pointer shall update only on a transition into OWN.
REQ-020 When several requests are simultaneous, exactly one grant bit shall be set; a master dropping CYC_IN in the same cycle as it wins shall still hold the grant for one cycle and then release it.

Reset
REQ-021 Asserting RST_ASYNC_N low shall immediately force: state IDLE, ARB_GNT_OUT = 0, last owner = 3, watchdog counter = 0, ARB_TIMEOUT_OUT = 0.
REQ-022 Reset asserted mid-transfer shall drop WB_M0_CYC_OUT/STB_OUT without waiting for ACK.
REQ-023 Release of RST_ASYNC_N shall be synchronized by the integrator; the first arbitration shall take place on the first enabled edge after release.

Configuration
REQ-024 Macro WB_ARB_WDOG_EN shall compile the watchdog in; without it, ABORT, the counter and the timeout logic shall be absent and ARB_TIMEOUT_OUT shall be tied to 0.
REQ-025 With the watchdog, an 8-bit counter shall clear on grant and on any WB_M0_ACK_IN or WB_M0_ERR_IN, increment each cycle while WB_M0_STB_OUT is high, and saturate.
REQ-026 When the counter reaches TIMEOUT_CYCLES-1 with no ACK/ERR that cycle, the following shall all occur:
  - the owner receives ERR_OUT = 1 for exactly one cycle;
  - ARB_TIMEOUT_OUT pulses;
  - the FSM enters ABORT.
REQ-027 In ABORT:
  - WB_M0_CYC_OUT/STB_OUT shall be 0;
  - the owner shall see STALL_OUT = 1 and ACK = 0;
  - the FSM shall hold until the owner's CYC_IN drops, then re-arbitrate per REQ-015.

Verification
REQ-028 Reset, then SL2 CYC=1 at cycle 0 -> ARB_GNT_OUT=4'b0100 from cycle 1; WB_M0_ADR_OUT follows SL2_ADR_IN.
REQ-029 All four CYC held high, each master drops CYC after one ACK -> grant order 0,1,2,3,0 with no idle cycles between owners.
REQ-030 SL0 owns while SL1 CYC=1 -> SL1 STALL_OUT=1, SL1 ACK_OUT=0, SL1 RD_DAT_OUT=0 until SL0 releases.
REQ-031 With WB_ARB_WDOG_EN and TIMEOUT_CYCLES=4, SL3 strobes and the slave never ACKs -> SL3 ERR_OUT and ARB_TIMEOUT_OUT high for one cycle, 4 cycles after the first STB, then WB_M0_CYC_OUT=0 until SL3 drops CYC.
REQ-032 RST_ASYNC_N pulsed low mid-burst, between clock edges -> ARB_GNT_OUT=0 and WB_M0_CYC_OUT=0 without waiting for a clock edge; after release, the next grant goes to master 0 if requesting.
REQ-033 Build without WB_ARB_WDOG_EN and a slave that never ACKs -> grant held indefinitely; ARB_TIMEOUT_OUT stays 0.
